irq_sync_filter: RTL
====================

IRQ_SYNC_FILTER -- requirements
Module: irq_sync_filter

Interface
REQ-001 SHALL have parameter NSRC, default 32, meaning number of interrupt sources (legal range 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth (legal range 2..3).
REQ-003 SHALL have parameter FILT_W, default 4, meaning filter counter and threshold width.
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all flops sit on its rising edge.
REQ-005 SHALL have port rst_i  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port irqs_raw_i  input  NSRC  meaning asynchronous raw interrupt lines from peripherals.
REQ-007 SHALL have port polarity_i  input  NSRC  meaning per source: 1 = active-low line, inverted after synchronization.
REQ-008 SHALL have port filt_en_i  input  NSRC  meaning per source: 1 = glitch filter enabled, 0 = bypass.
REQ-009 SHALL have port filt_len_i  input  FILT_W  meaning the filter threshold L, shared by all sources.
REQ-010 SHALL have port irqs_o  output  NSRC  meaning conditioned active-high levels; drives the PLIC irqs_i.
REQ-011 SHALL have port rise_o  output  NSRC  meaning one-cycle pulse on each 0->1 transition of irqs_o.

Function
REQ-012 SHALL pass each irqs_raw_i bit through SYNC_STAGES flops; the last stage is sync[i].
REQ-013 SHALL form s[i] = sync[i] XOR polarity_i[i]. A polarity_i change is treated as an input change and is filtered like one.
REQ-014 SHALL hold a warm-up counter for the SYNC_STAGES cycles after reset deassertion. While it runs, irqs_o, rise_o and all filter counters SHALL stay 0.
REQ-015 SHALL, after warm-up with filt_en_i[i]=0, register irqs_o[i] <= s[i] every cycle and hold cnt[i] at 0.
REQ-016 SHALL, after warm-up with filt_en_i[i]=1, update per source on each edge:
- if s[i]==irqs_o[i]: cnt[i] <= 0;
- else if cnt[i] >= filt_len_i: irqs_o[i] <= s[i] and cnt[i] <= 0;
- else: cnt[i] <= cnt[i]+1.
REQ-017 SHALL therefore require a new level to persist for L+1 consecutive post-sync samples before it propagates. L=0 SHALL behave exactly like bypass.
REQ-018 SHALL have a latency, from the capture edge k of a raw change, of irqs_o updating at edge k+SYNC_STAGES+L (bypass: L=0).
REQ-019 SHALL discard a glitch shorter than L+1 post-sync cycles: the counter clears and irqs_o does not change.
REQ-020 SHALL handle a filt_len_i decrease below cnt[i] by updating on the next edge (>= compare). cnt[i] SHALL never exceed 2^FILT_W-1 or wrap.
REQ-021 SHALL handle a filt_en_i 1->0 change by switching that source to bypass on the next edge and clearing cnt[i]. A 0->1 change starts counting from 0.
REQ-022 SHALL register rise_o[i] so it is 1 exactly in the cycle where irqs_o[i] first reads 1 after reading 0, and 0 otherwise. A falling edge SHALL give no pulse.
REQ-023 SHALL keep every source independent: no cross-source coupling except the shared filt_len_i.

Reset
REQ-024 SHALL, while rst_i=1, asynchronously clear all sync flops, filter counters, the warm-up counter, irqs_o and rise_o to 0.
REQ-025 SHALL, on reset assertion mid-filter or mid-pulse, abort immediately; no rise_o pulse is emitted for that event.
REQ-026 SHALL restart warm-up per REQ-014 after reset release. An active-low idle-high line (polarity_i=1, raw=1) SHALL then read irqs_o=0 with no spurious rise_o.

Verification
REQ-027 SHALL cover bypass, SYNC_STAGES=2: raw[0] 0->1 captured at edge k -> irqs_o[0]=1 and rise_o[0]=1 at edge k+2; rise_o[0]=0 at k+3.
REQ-028 SHALL cover the filter with L=3 and filt_en[5]=1:
- a 3-cycle high glitch -> irqs_o[5] stays 0 and cnt returns to 0;
- a 6-cycle high level -> irqs_o[5]=1 at edge k+5.
REQ-029 SHALL cover polarity: polarity[7]=1, raw[7] held 1 through reset -> irqs_o[7]=0 after warm-up. Drive raw[7] to 0 -> irqs_o[7]=1 after the latency with one rise_o pulse.
REQ-030 SHALL cover a threshold change: L=15 mid-count at cnt=8, then filt_len_i set to 4 -> irqs_o updates on the next edge.
REQ-031 SHALL cover reset mid-operation: assert rst_i asynchronously (between edges) while cnt[2]=2 -> irqs_o, rise_o and cnt read 0 immediately. After release, outputs stay 0 for the SYNC_STAGES warm-up cycles.
REQ-032 SHALL cover independence: all 32 sources toggled with random lengths and random filt_en -> each irqs_o bit matches a per-source reference model cycle-exactly.

Source files
------------

// File: rtl/irq_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_filter
// Purpose  : Interrupt input conditioning ahead of the PLIC. Each raw line
//            is synchronized, optionally inverted (active-low sources), and
//            optionally glitch-filtered. A one-cycle rising-edge pulse is
//            produced for every 0->1 transition of the conditioned level.
// Ports    :
//   clk_i       - single clock, rising edge
//   rst_i       - asynchronous active-high reset
//   irqs_raw_i  - [NSRC] raw asynchronous interrupt lines
//   polarity_i  - [NSRC] 1 = line is active-low (inverted after the sync)
//   filt_en_i   - [NSRC] 1 = glitch filter enabled, 0 = bypass
//   filt_len_i  - [FILT_W] filter threshold L shared by all sources
//   irqs_o      - [NSRC] conditioned active-high levels
//   rise_o      - [NSRC] one-cycle pulse on each 0->1 of irqs_o
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync_filter #(
  parameter int NSRC        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NSRC-1:0]   irqs_raw_i,
  input  logic [NSRC-1:0]   polarity_i,
  input  logic [NSRC-1:0]   filt_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic [NSRC-1:0]   irqs_o,
  output logic [NSRC-1:0]   rise_o
);

  // SYNC_STAGES is at most 3, so two bits hold the warm-up count.
  localparam int                WARM_W   = 2;
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(SYNC_STAGES);
  localparam logic [WARM_W-1:0] WARM_ONE = WARM_W'(1);
  localparam logic [FILT_W-1:0] CNT_ONE  = FILT_W'(1);

  // --------------------------------------------------------------------------
  // Synchronizer chain: stage 0 captures the raw line, the last stage is the
  // first value safe to use in logic.
  // --------------------------------------------------------------------------
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] sync_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= '0;
      end
    end else begin
      sync_q[0] <= irqs_raw_i;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Warm-up: the synchronizer was cleared by reset, so its last stage does
  // not reflect the real line until SYNC_STAGES edges have passed. Without
  // this, an idle-high active-low line would briefly look asserted and emit
  // a spurious rise pulse.
  // --------------------------------------------------------------------------
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;

  assign warm_done = (warm_cnt == WARM_END);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + WARM_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Per-source filter. A new level must be seen for L+1 consecutive samples:
  // the counter advances while the sampled level differs from the output and
  // the output flips on the sample where the count has reached L. The >=
  // compare lets a threshold lowered below the running count take effect on
  // the very next edge; the counter only advances while below L, so it can
  // never wrap.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic              lvl;
    logic              irq_q;
    logic              irq_nxt;
    logic              rise_q;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_nxt;

    assign lvl = sync_last[i] ^ polarity_i[i];

    always_comb begin
      irq_nxt = irq_q;
      cnt_nxt = '0;
      if (!filt_en_i[i]) begin
        irq_nxt = lvl;
      end else if (lvl != irq_q) begin
        if (cnt_q >= filt_len_i) begin
          irq_nxt = lvl;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        irq_q  <= 1'b0;
        cnt_q  <= '0;
        rise_q <= 1'b0;
      end else if (!warm_done) begin
        irq_q  <= 1'b0;
        cnt_q  <= '0;
        rise_q <= 1'b0;
      end else begin
        irq_q  <= irq_nxt;
        cnt_q  <= cnt_nxt;
        // Registered alongside the level so the pulse lines up with the
        // first cycle irqs_o reads 1.
        rise_q <= irq_nxt & ~irq_q;
      end
    end

    assign irqs_o[i] = irq_q;
    assign rise_o[i] = rise_q;
  end

endmodule
`default_nettype wire
